// File: rtl/dbg_ocimem_ctrl.sv
// Debug on-chip memory controller: JTAG command sequencer, debug RAM and monitor flags,
// arbitrating JTAG against CPU debug-slave Avalon accesses.
module dbg_ocimem_ctrl #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              debugaccess,
  input  logic [ADDR_W:0]   avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StJRd, StCRd} state_e;
  typedef enum logic [1:0] {CmdA, CmdB, CmdN} cmd_e;

  state_e            state_q;
  logic              pend_q;
  cmd_e              pend_cmd_q;
  logic [35:3]       pend_jdo_q;
  logic [ADDR_W-1:0] mon_areg_q;
  logic [31:0]       mon_dreg_q;
  logic              rdy_q, err_q;
  logic              incr_q;
  logic              csr_sel_q;
  logic [31:0]       csr_q;
  logic [31:0]       rdata_hold_q;
  logic [31:0]       ram_q;
  logic [31:0]       mem [Depth];

  logic              strobe_any, cpu_is_csr, jtag_go, cpu_go, cpu_rd_go, cpu_wr_go;
  logic [ADDR_W-1:0] cpu_addr, jdo_addr;
  logic              ram_re;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_raddr, ram_waddr;
  logic [31:0]       ram_wdata;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign cpu_is_csr = avs_address[ADDR_W];
  assign cpu_addr   = avs_address[ADDR_W-1:0];
  assign jdo_addr   = pend_jdo_q[25+ADDR_W:26];
  assign jtag_go    = (state_q == StIdle) && pend_q;
  // A strobe arriving this cycle already outranks the CPU, even before it lands in pend_q.
  assign cpu_go     = (state_q == StIdle) && !pend_q && !strobe_any;
  assign cpu_rd_go  = cpu_go && avs_read;
  assign cpu_wr_go  = cpu_go && avs_write && !avs_read;

  always_comb begin
    ram_re    = 1'b0;
    ram_raddr = mon_areg_q;
    ram_we    = 4'h0;
    ram_waddr = mon_areg_q;
    ram_wdata = pend_jdo_q[34:3];
    if (jtag_go) begin
      case (pend_cmd_q)
        CmdA: begin
          if (pend_jdo_q[34]) begin
            ram_re    = 1'b1;
            ram_raddr = jdo_addr;
          end
        end
        CmdB:    ram_we = 4'hF;
        default: ram_re = 1'b1;
      endcase
    end else if (cpu_rd_go && !cpu_is_csr) begin
      ram_re    = 1'b1;
      ram_raddr = cpu_addr;
    end else if (cpu_wr_go && !cpu_is_csr && debugaccess) begin
      ram_we    = avs_byteenable;
      ram_waddr = cpu_addr;
      ram_wdata = avs_writedata;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we[i]) mem[ram_waddr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
    if (ram_re) ram_q <= mem[ram_raddr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pend_q       <= 1'b0;
      pend_cmd_q   <= CmdA;
      pend_jdo_q   <= '0;
      mon_areg_q   <= '0;
      mon_dreg_q   <= '0;
      rdy_q        <= 1'b0;
      err_q        <= 1'b0;
      incr_q       <= 1'b0;
      csr_sel_q    <= 1'b0;
      csr_q        <= '0;
      rdata_hold_q <= '0;
    end else begin
      if (jtag_go) pend_q <= 1'b0;
      // Last strobe wins; a strobe coinciding with service re-arms the pending slot.
      if (strobe_any) begin
        pend_q     <= 1'b1;
        pend_jdo_q <= jdo[35:3];
        pend_cmd_q <= take_action_ocimem_a ? CmdA : (take_action_ocimem_b ? CmdB : CmdN);
      end
      unique case (state_q)
        StIdle: begin
          if (jtag_go) begin
            case (pend_cmd_q)
              CmdA: begin
                mon_areg_q <= jdo_addr;
                if (pend_jdo_q[35]) begin
                  rdy_q <= 1'b0;
                  err_q <= 1'b0;
                end
                if (pend_jdo_q[34]) begin
                  incr_q  <= 1'b0;
                  state_q <= StJRd;
                end
              end
              CmdB:    mon_areg_q <= mon_areg_q + 1'b1;
              default: begin
                incr_q  <= 1'b1;
                state_q <= StJRd;
              end
            endcase
          end else if (cpu_rd_go) begin
            csr_sel_q <= cpu_is_csr;
            csr_q     <= (cpu_addr == '0) ? {30'b0, err_q, rdy_q} : 32'h0;
            state_q   <= StCRd;
          end else if (cpu_wr_go && cpu_is_csr && (cpu_addr == '0)) begin
            if (avs_writedata[0]) rdy_q <= 1'b1;
            if (avs_writedata[1]) err_q <= 1'b1;
          end
        end
        StJRd: begin
          mon_dreg_q <= ram_q;
          if (incr_q) mon_areg_q <= mon_areg_q + 1'b1;
          state_q <= StIdle;
        end
        StCRd: begin
          rdata_hold_q <= avs_readdata;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign avs_readdata = (state_q == StCRd) ? (csr_sel_q ? csr_q : ram_q) : rdata_hold_q;

  always_comb begin
    avs_waitrequest = 1'b0;
    unique case (state_q)
      StIdle:  avs_waitrequest = (pend_q || strobe_any) ? (avs_read || avs_write) : avs_read;
      StJRd:   avs_waitrequest = avs_read || avs_write;
      default: avs_waitrequest = 1'b0;
    endcase
    if (reset) avs_waitrequest = 1'b1;
  end

  assign MonDReg       = mon_dreg_q;
  assign monitor_ready = rdy_q;
  assign monitor_error = err_q;

endmodule
